// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo: turns PS/2 set-2 scan-code bytes into ASCII key presses.
// Tracks the break and extended prefixes and the Shift, Ctrl and Caps Lock state.
// Translated bytes go into a show-ahead FIFO that the CPU pops.
module ps2_ascii_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    code,
    input  logic          code_valid,
    input  logic          rd_en,
    input  logic          clear,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          shift_o,
    output logic          ctrl_o,
    output logic          caps_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic          shiftL_q, shiftL_d, shiftR_q, shiftR_d;
    logic          ctrl_q, ctrl_d, caps_q, caps_d;
    logic          shift, isLetter;
    logic [7:0]    plainChar, shiftChar, keyChar, extChar, pushByte;
    logic [AW:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, used;
    logic          overflow_q, overflow_d;
    logic          full, empty, pushReq, doPush, doPop;
    logic [7:0]    mem_q [DEPTH];

    assign shift = shiftL_q | shiftR_q;

    // Look up a non-extended key and apply the modifiers to get its character.
    always_comb begin
        isLetter  = 1'b0;
        plainChar = 8'h00;
        shiftChar = 8'h00;
        keyChar   = 8'h00;
        case (code)
            8'h1C: begin isLetter = 1'b1; plainChar = 8'h61; end
            8'h32: begin isLetter = 1'b1; plainChar = 8'h62; end
            8'h21: begin isLetter = 1'b1; plainChar = 8'h63; end
            8'h23: begin isLetter = 1'b1; plainChar = 8'h64; end
            8'h24: begin isLetter = 1'b1; plainChar = 8'h65; end
            8'h2B: begin isLetter = 1'b1; plainChar = 8'h66; end
            8'h34: begin isLetter = 1'b1; plainChar = 8'h67; end
            8'h33: begin isLetter = 1'b1; plainChar = 8'h68; end
            8'h43: begin isLetter = 1'b1; plainChar = 8'h69; end
            8'h3B: begin isLetter = 1'b1; plainChar = 8'h6A; end
            8'h42: begin isLetter = 1'b1; plainChar = 8'h6B; end
            8'h4B: begin isLetter = 1'b1; plainChar = 8'h6C; end
            8'h3A: begin isLetter = 1'b1; plainChar = 8'h6D; end
            8'h31: begin isLetter = 1'b1; plainChar = 8'h6E; end
            8'h44: begin isLetter = 1'b1; plainChar = 8'h6F; end
            8'h4D: begin isLetter = 1'b1; plainChar = 8'h70; end
            8'h15: begin isLetter = 1'b1; plainChar = 8'h71; end
            8'h2D: begin isLetter = 1'b1; plainChar = 8'h72; end
            8'h1B: begin isLetter = 1'b1; plainChar = 8'h73; end
            8'h2C: begin isLetter = 1'b1; plainChar = 8'h74; end
            8'h3C: begin isLetter = 1'b1; plainChar = 8'h75; end
            8'h2A: begin isLetter = 1'b1; plainChar = 8'h76; end
            8'h1D: begin isLetter = 1'b1; plainChar = 8'h77; end
            8'h22: begin isLetter = 1'b1; plainChar = 8'h78; end
            8'h35: begin isLetter = 1'b1; plainChar = 8'h79; end
            8'h1A: begin isLetter = 1'b1; plainChar = 8'h7A; end
            8'h45: begin plainChar = 8'h30; shiftChar = 8'h29; end
            8'h16: begin plainChar = 8'h31; shiftChar = 8'h21; end
            8'h1E: begin plainChar = 8'h32; shiftChar = 8'h40; end
            8'h26: begin plainChar = 8'h33; shiftChar = 8'h23; end
            8'h25: begin plainChar = 8'h34; shiftChar = 8'h24; end
            8'h2E: begin plainChar = 8'h35; shiftChar = 8'h25; end
            8'h36: begin plainChar = 8'h36; shiftChar = 8'h5E; end
            8'h3D: begin plainChar = 8'h37; shiftChar = 8'h26; end
            8'h3E: begin plainChar = 8'h38; shiftChar = 8'h2A; end
            8'h46: begin plainChar = 8'h39; shiftChar = 8'h28; end
            8'h4E: begin plainChar = 8'h2D; shiftChar = 8'h5F; end
            8'h55: begin plainChar = 8'h3D; shiftChar = 8'h2B; end
            8'h54: begin plainChar = 8'h5B; shiftChar = 8'h7B; end
            8'h5B: begin plainChar = 8'h5D; shiftChar = 8'h7D; end
            8'h5D: begin plainChar = 8'h5C; shiftChar = 8'h7C; end
            8'h4C: begin plainChar = 8'h3B; shiftChar = 8'h3A; end
            8'h52: begin plainChar = 8'h27; shiftChar = 8'h22; end
            8'h0E: begin plainChar = 8'h60; shiftChar = 8'h7E; end
            8'h41: begin plainChar = 8'h2C; shiftChar = 8'h3C; end
            8'h49: begin plainChar = 8'h2E; shiftChar = 8'h3E; end
            8'h4A: begin plainChar = 8'h2F; shiftChar = 8'h3F; end
            8'h29: begin plainChar = 8'h20; shiftChar = 8'h20; end
            8'h5A: begin plainChar = 8'h0D; shiftChar = 8'h0D; end
            8'h66: begin plainChar = 8'h08; shiftChar = 8'h08; end
            8'h0D: begin plainChar = 8'h09; shiftChar = 8'h09; end
            8'h76: begin plainChar = 8'h1B; shiftChar = 8'h1B; end
            default: begin plainChar = 8'h00; shiftChar = 8'h00; end
        endcase
        if (isLetter) begin
            if (ctrl_q)
                keyChar = plainChar & 8'h1F;
            else if (shift ^ caps_q)
                keyChar = plainChar - 8'h20;
            else
                keyChar = plainChar;
        end else begin
            keyChar = shift ? shiftChar : plainChar;
        end
    end

    // Characters for the keys that follow an E0 prefix (keypad Enter, keypad slash, arrows).
    always_comb begin
        extChar = 8'h00;
        case (code)
            8'h5A:   extChar = 8'h0D;
            8'h4A:   extChar = 8'h2F;
            8'h75:   extChar = 8'h80;
            8'h72:   extChar = 8'h81;
            8'h6B:   extChar = 8'h82;
            8'h74:   extChar = 8'h83;
            default: extChar = 8'h00;
        endcase
    end

    // Prefix FSM: decides modifier changes and which byte (if any) a received code pushes.
    always_comb begin
        state_d  = state_q;
        shiftL_d = shiftL_q;
        shiftR_d = shiftR_q;
        ctrl_d   = ctrl_q;
        caps_d   = caps_q;
        pushByte = 8'h00;
        if (code_valid) begin
            unique case (state_q)
                IDLE: begin
                    case (code)
                        8'hF0:   state_d  = BRK;
                        8'hE0:   state_d  = EXT;
                        8'h12:   shiftL_d = 1'b1;
                        8'h59:   shiftR_d = 1'b1;
                        8'h14:   ctrl_d   = 1'b1;
                        8'h58:   caps_d   = ~caps_q;
                        default: pushByte = keyChar;
                    endcase
                end
                BRK: begin
                    state_d = IDLE;
                    case (code)
                        8'h12:   shiftL_d = 1'b0;
                        8'h59:   shiftR_d = 1'b0;
                        8'h14:   ctrl_d   = 1'b0;
                        default: state_d  = IDLE;
                    endcase
                end
                EXT: begin
                    if (code == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                        if (code == 8'h14)
                            ctrl_d = 1'b1;
                        pushByte = extChar;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (code == 8'h14)
                        ctrl_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FIFO control: clear wins, a full FIFO only accepts a push when a pop frees a slot.
    always_comb begin
        used       = wrPtr_q - rdPtr_q;
        full       = (used == FULL_COUNT);
        empty      = (used == '0);
        pushReq    = code_valid && (pushByte != 8'h00);
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        overflow_d = overflow_q;
        doPush     = 1'b0;
        doPop      = 1'b0;
        if (clear) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            overflow_d = 1'b0;
        end else begin
            doPop  = rd_en && !empty;
            doPush = pushReq && (!full || rd_en);
            if (pushReq && full && !rd_en)
                overflow_d = 1'b1;
            if (doPop)
                rdPtr_d = rdPtr_q + 1'b1;
            if (doPush)
                wrPtr_d = wrPtr_q + 1'b1;
        end
    end

    // State, modifier, pointer and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftL_q   <= 1'b0;
            shiftR_q   <= 1'b0;
            ctrl_q     <= 1'b0;
            caps_q     <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftL_q   <= shiftL_d;
            shiftR_q   <= shiftR_d;
            ctrl_q     <= ctrl_d;
            caps_q     <= caps_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; entries need no reset because reads are gated by empty.
    always_ff @(posedge clk) begin
        if (doPush)
            mem_q[wrPtr_q[AW-1:0]] <= pushByte;
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? 8'h00 : mem_q[rdPtr_q[AW-1:0]];
    assign count    = used;
    assign overflow = overflow_q;
    assign shift_o  = shift;
    assign ctrl_o   = ctrl_q;
    assign caps_o   = caps_q;

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// tb_ps2_ascii_fifo: table-driven, hand-written and randomized checks of ps2_ascii_fifo.
module tb_ps2_ascii_fifo;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    code;
    logic          code_valid;
    logic          rd_en;
    logic          clear;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          overflow;
    logic          shift_o;
    logic          ctrl_o;
    logic          caps_o;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: prefix flags, modifiers, a queue of characters.
    bit            mBrk, mExt, mShiftL, mShiftR, mCtrl, mCaps, mOverflow;
    logic [7:0]    mQ[$];

    typedef struct {
        logic       sh;
        logic       cp;
        logic       ct;
        logic [7:0] c;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    ps2_ascii_fifo #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .code(code), .code_valid(code_valid),
        .rd_en(rd_en), .clear(clear), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .overflow(overflow), .shift_o(shift_o), .ctrl_o(ctrl_o),
        .caps_o(caps_o)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [7:0] translateKey(input logic [7:0] c, input bit sh,
                                                input bit cp, input bit ct);
        logic [7:0] letterCodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
            8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] otherCodes [21] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
            8'h3D, 8'h3E, 8'h46, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h0E,
            8'h41, 8'h49, 8'h4A};
        logic [7:0] otherLo [21] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
            8'h37, 8'h38, 8'h39, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h60,
            8'h2C, 8'h2E, 8'h2F};
        logic [7:0] otherHi [21] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E,
            8'h26, 8'h2A, 8'h28, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h7E,
            8'h3C, 8'h3E, 8'h3F};
        logic [7:0] lower;
        for (int i = 0; i < 26; i++) begin
            if (c == letterCodes[i]) begin
                lower = 8'(8'h61 + i);
                if (ct) return lower & 8'h1F;
                return (sh ^ cp) ? 8'(8'h41 + i) : lower;
            end
        end
        for (int i = 0; i < 21; i++)
            if (c == otherCodes[i]) return sh ? otherHi[i] : otherLo[i];
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h0D:   return 8'h09;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] extKey(input logic [7:0] c);
        case (c)
            8'h5A:   return 8'h0D;
            8'h4A:   return 8'h2F;
            8'h75:   return 8'h80;
            8'h72:   return 8'h81;
            8'h6B:   return 8'h82;
            8'h74:   return 8'h83;
            default: return 8'h00;
        endcase
    endfunction

    task automatic modelReset();
        mBrk = 0; mExt = 0; mShiftL = 0; mShiftR = 0; mCtrl = 0; mCaps = 0; mOverflow = 0;
        mQ.delete();
    endtask

    task automatic modelCycle(input logic cv, input logic [7:0] c, input logic rdEn,
                              input logic clr);
        logic [7:0] pb;
        pb = 8'h00;
        if (cv) begin
            if (mBrk) begin
                if (c == 8'h14) mCtrl = 0;
                if (!mExt && c == 8'h12) mShiftL = 0;
                if (!mExt && c == 8'h59) mShiftR = 0;
                mBrk = 0;
                mExt = 0;
            end else if (mExt) begin
                if (c == 8'hF0) begin
                    mBrk = 1;
                end else begin
                    mExt = 0;
                    if (c == 8'h14) mCtrl = 1;
                    pb = extKey(c);
                end
            end else begin
                case (c)
                    8'hF0:   mBrk = 1;
                    8'hE0:   mExt = 1;
                    8'h12:   mShiftL = 1;
                    8'h59:   mShiftR = 1;
                    8'h14:   mCtrl = 1;
                    8'h58:   mCaps = !mCaps;
                    default: pb = translateKey(c, mShiftL | mShiftR, mCaps, mCtrl);
                endcase
            end
        end
        if (clr) begin
            mQ.delete();
            mOverflow = 0;
        end else begin
            if (rdEn && mQ.size() > 0) void'(mQ.pop_front());
            if (pb != 8'h00) begin
                if (mQ.size() < DEPTH) mQ.push_back(pb);
                else mOverflow = 1;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus, mirrored into the model; returns 1 ns after the edge.
    task automatic applyStimulus(input logic cv, input logic [7:0] c, input logic rdEn,
                                 input logic clr);
        code_valid = cv;
        code       = c;
        rd_en      = rdEn;
        clear      = clr;
        modelCycle(cv, c, rdEn, clr);
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'h00;
        rd_en      = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " rd_data"}, 32'(rd_data), 32'((mQ.size() > 0) ? mQ[0] : 8'h00));
        checkVal({tag, " rd_valid"}, 32'(rd_valid), 32'(mQ.size() > 0));
        checkVal({tag, " count"}, 32'(count), 32'(mQ.size()));
        checkVal({tag, " overflow"}, 32'(overflow), 32'(mOverflow));
        checkVal({tag, " shift_o"}, 32'(shift_o), 32'(mShiftL | mShiftR));
        checkVal({tag, " ctrl_o"}, 32'(ctrl_o), 32'(mCtrl));
        checkVal({tag, " caps_o"}, 32'(caps_o), 32'(mCaps));
    endtask

    task automatic sendCode(input logic [7:0] c);
        applyStimulus(1'b1, c, 1'b0, 1'b0);
    endtask

    task automatic popCheck(input string name, input logic [7:0] exp);
        checkVal(name, 32'(rd_data), 32'(exp));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        modelReset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pool [34] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h35, 8'h45, 8'h16, 8'h36,
            8'h4E, 8'h5D, 8'h52, 8'h0E, 8'h4A, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h12,
            8'h59, 8'h14, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h75, 8'h72, 8'h6B, 8'h74,
            8'hAA, 8'hFA, 8'h00, 8'h01};
        logic [7:0] nineKeys [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43};
        rst_n = 1'b0; code = 8'h00; code_valid = 1'b0; rd_en = 1'b0; clear = 1'b0;
        modelReset();
        #12;

        // Single-key translation table: {shift, caps, ctrl, code, expected char}.
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h1C, 8'h61});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h1C, 8'h41});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h1C, 8'h41});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h1C, 8'h61});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h21, 8'h03});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h1A, 8'h1A});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h45, 8'h30});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h45, 8'h29});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h1E, 8'h40});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h36, 8'h5E});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h16, 8'h31});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h16, 8'h31});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h4A, 8'h3F});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h0E, 8'h60});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h0E, 8'h7E});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h5D, 8'h7C});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h52, 8'h27});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h52, 8'h22});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h29, 8'h20});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h5A, 8'h0D});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h76, 8'h1B});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h66, 8'h08});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h0D, 8'h09});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'hAA, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'hFA, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'hEE, 8'h00});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 8'h01, 8'h00});

        for (int i = 0; i < vecs.size(); i++) begin
            doReset();
            if (vecs[i].sh) sendCode(8'h12);
            if (vecs[i].cp) sendCode(8'h58);
            if (vecs[i].ct) sendCode(8'h14);
            sendCode(vecs[i].c);
            if (vecs[i].exp != 8'h00) begin
                checkVal($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp));
                checkVal($sformatf("vec%0d count", i), 32'(count), 32'd1);
            end else begin
                checkVal($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'd0);
                checkVal($sformatf("vec%0d count", i), 32'(count), 32'd0);
            end
        end

        // Reset values, first push, pop back to empty, pop while empty.
        doReset();
        checkVal("rst rd_data", 32'(rd_data), 32'd0);
        checkVal("rst rd_valid", 32'(rd_valid), 32'd0);
        checkVal("rst count", 32'(count), 32'd0);
        checkVal("rst overflow", 32'(overflow), 32'd0);
        checkVal("rst shift_o", 32'(shift_o), 32'd0);
        checkVal("rst ctrl_o", 32'(ctrl_o), 32'd0);
        checkVal("rst caps_o", 32'(caps_o), 32'd0);
        sendCode(8'h1C);
        checkVal("first rd_data", 32'(rd_data), 32'h61);
        checkVal("first count", 32'(count), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("pop rd_valid", 32'(rd_valid), 32'd0);
        checkVal("pop rd_data", 32'(rd_data), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkVal("empty pop count", 32'(count), 32'd0);

        // Shift make/break, left and right.
        doReset();
        sendCode(8'h12);
        checkVal("shift on", 32'(shift_o), 32'd1);
        sendCode(8'h1C); sendCode(8'hF0);
        checkVal("F0 no push", 32'(count), 32'd1);
        sendCode(8'h12);
        checkVal("shift off", 32'(shift_o), 32'd0);
        sendCode(8'h1C);
        checkVal("shift seq count", 32'(count), 32'd2);
        popCheck("shift seq A", 8'h41);
        popCheck("shift seq a", 8'h61);
        sendCode(8'h59);
        checkVal("rshift on", 32'(shift_o), 32'd1);
        sendCode(8'hF0); sendCode(8'h59);
        checkVal("rshift off", 32'(shift_o), 32'd0);

        // Caps Lock affects letters only.
        doReset();
        sendCode(8'h58);
        checkVal("caps on", 32'(caps_o), 32'd1);
        sendCode(8'h1C); sendCode(8'h16); sendCode(8'h12); sendCode(8'h1C); sendCode(8'h16);
        checkVal("caps count", 32'(count), 32'd4);
        popCheck("caps A", 8'h41);
        popCheck("caps 1", 8'h31);
        popCheck("caps a", 8'h61);
        popCheck("caps !", 8'h21);

        // Ctrl, extended break of right Ctrl, arrows and keypad keys.
        doReset();
        sendCode(8'h14); sendCode(8'h21);
        checkVal("ctrl on", 32'(ctrl_o), 32'd1);
        sendCode(8'hE0); sendCode(8'hF0); sendCode(8'h14);
        checkVal("ctrl off ext", 32'(ctrl_o), 32'd0);
        sendCode(8'hE0); sendCode(8'h75); sendCode(8'hE0); sendCode(8'h5A);
        sendCode(8'hE0); sendCode(8'h12);
        checkVal("E0 12 no shift", 32'(shift_o), 32'd0);
        sendCode(8'hE0); sendCode(8'h4A);
        sendCode(8'hE0); sendCode(8'h14);
        checkVal("ext ctrl on", 32'(ctrl_o), 32'd1);
        checkVal("ext count", 32'(count), 32'd4);
        popCheck("ctrl c", 8'h03);
        popCheck("up", 8'h80);
        popCheck("kp enter", 8'h0D);
        popCheck("kp slash", 8'h2F);

        // Overflow, full push+pop, clear, clear beating a push.
        doReset();
        for (int i = 0; i < 9; i++) sendCode(nineKeys[i]);
        checkVal("ovf count", 32'(count), 32'd8);
        checkVal("ovf flag", 32'(overflow), 32'd1);
        checkVal("ovf head", 32'(rd_data), 32'h61);
        applyStimulus(1'b1, 8'h42, 1'b1, 1'b0);
        checkVal("full rw count", 32'(count), 32'd8);
        checkVal("full rw ovf", 32'(overflow), 32'd1);
        checkVal("full rw head", 32'(rd_data), 32'h62);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkVal("clear count", 32'(count), 32'd0);
        checkVal("clear ovf", 32'(overflow), 32'd0);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b1);
        checkVal("clear vs push", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) sendCode(nineKeys[i]);
        applyStimulus(1'b1, 8'h42, 1'b1, 1'b0);
        checkVal("full rw no ovf", 32'(overflow), 32'd0);
        checkVal("full rw count2", 32'(count), 32'd8);
        doReset();
        applyStimulus(1'b1, 8'h1C, 1'b1, 1'b0);
        checkVal("empty rw count", 32'(count), 32'd1);
        checkVal("empty rw data", 32'(rd_data), 32'h61);

        // Reset between F0 and its key: the key is then a make.
        doReset();
        sendCode(8'hF0);
        doReset();
        sendCode(8'h1C);
        checkVal("midframe data", 32'(rd_data), 32'h61);
        sendCode(8'hAA); sendCode(8'hFA);
        checkVal("AA FA count", 32'(count), 32'd1);

        // Randomized traffic against the model, with read-starved and read-heavy phases.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            logic cv, rdEn, clr;
            cv   = ($urandom_range(0, 2) != 0);
            rdEn = (i % 300 < 150) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            clr  = ($urandom_range(0, 79) == 0);
            applyStimulus(cv, pool[$urandom_range(0, 33)], rdEn, clr);
            checkOutput($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
